// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead accumulator.
package cla_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-lookahead adder slice; carries come from generate/propagate terms.
module cla_slice4
   import cla_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   logic [NIBBLE_W-1:0] g;
   logic [NIBBLE_W-1:0] p;
   logic [NIBBLE_W:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // Each carry is a flat sum of products, so no carry waits on the one below it.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum  = p ^ c[NIBBLE_W-1:0];
   assign cout = c[NIBBLE_W];

endmodule

// File: rtl/cla_accumulator.sv
// Accumulator that adds one operand per operation, one nibble per cycle,
// through a single shared 4-bit carry-lookahead slice.
module cla_accumulator
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NIB   = WIDTH / NIBBLE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] acc,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned      IDX_W    = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0]    operand_q, operand_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                carry_q, carry_d;
   logic                carry_out_q, carry_out_d;
   logic                overflow_q, overflow_d;
   logic                out_valid_q, out_valid_d;

   logic [NIBBLE_W-1:0] op_nib;
   logic [NIBBLE_W-1:0] acc_nib;
   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_cout;
   logic                last_nib;

   assign in_ready = (state_q == IDLE) && !clear;
   assign last_nib = (idx_q == LAST_IDX);

   // Route the current nibble of operand and accumulator into the slice.
   always_comb begin
      op_nib  = '0;
      acc_nib = '0;
      for (int unsigned i = 0; i < NIB; i++) begin
         if (idx_q == IDX_W'(i)) begin
            op_nib  = operand_q[i*NIBBLE_W +: NIBBLE_W];
            acc_nib = acc_q[i*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   cla_slice4 u_slice (
      .a    (op_nib),
      .b    (acc_nib),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // State register and datapath flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         operand_q   <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         operand_q   <= operand_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Next-state logic; clear takes priority over a new operand in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!clear && in_valid) state_d = ADD;
         ADD:     if (last_nib)           state_d = HOLD;
         HOLD:    if (out_ready)          state_d = IDLE;
         default:                         state_d = IDLE;
      endcase
   end

   // Datapath and output updates for each state.
   always_comb begin
      acc_d       = acc_q;
      operand_d   = operand_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      case (state_q)
         IDLE: begin
            if (clear) begin
               acc_d       = '0;
               carry_out_d = 1'b0;
               overflow_d  = 1'b0;
            end else if (in_valid) begin
               operand_d = in_data;
               idx_d     = '0;
               carry_d   = 1'b0;
            end
         end
         ADD: begin
            for (int unsigned i = 0; i < NIB; i++) begin
               if (idx_q == IDX_W'(i)) acc_d[i*NIBBLE_W +: NIBBLE_W] = slice_sum;
            end
            carry_d = slice_cout;
            idx_d   = idx_q + IDX_W'(1);
            if (last_nib) begin
               carry_out_d = slice_cout;
               overflow_d  = overflow_q | slice_cout;
            end
         end
         default: ;
      endcase
      out_valid_d = (state_d == HOLD);
   end

   assign acc       = acc_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cla_accumulator.sv
// Scoreboard bench for cla_accumulator at WIDTH=16: expected results are queued
// at accept time from a plain integer model and compared when out_valid appears.
module tb_cla_accumulator;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NIB   = WIDTH / 4;

   typedef struct packed {
      logic [WIDTH-1:0] acc;
      logic             carry;
      logic             ovf;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] acc;
   logic             carry_out;
   logic             overflow;

   exp_t             sb_q[$];
   logic [WIDTH-1:0] acc_m;
   logic             ovf_m;
   int               n_checks;
   int               n_pass;

   cla_accumulator #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc       (acc),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // One full operation: accept, count latency, optionally stall in HOLD, then drain.
   task automatic do_op(input logic [WIDTH-1:0] data, input int hold, input bit clr_in_add);
      int               n;
      logic [WIDTH:0]   s;
      logic [WIDTH-1:0] acc_snap;
      exp_t             e;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      check("ready_before_accept", in_ready, 1);
      in_valid = 1'b1;
      in_data  = data;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = '0;
      s     = {1'b0, acc_m} + {1'b0, data};
      acc_m = s[WIDTH-1:0];
      ovf_m = ovf_m | s[WIDTH];
      sb_q.push_back('{acc: acc_m, carry: s[WIDTH], ovf: ovf_m});
      if (clr_in_add) clear = 1'b1;
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      clear = 1'b0;
      check("latency", 32'(n), 32'(NIB));
      acc_snap = acc;
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", out_valid, 1);
         check("hold_acc", acc, acc_snap);
         check("hold_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      if (sb_q.size() == 0) begin
         check("sb_nonempty", 0, 1);
      end else begin
         e = sb_q.pop_front();
         check("acc", acc, e.acc);
         check("carry_out", carry_out, e.carry);
         check("overflow", overflow, e.ovf);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("idle_out_valid", out_valid, 0);
      check("idle_in_ready", in_ready, 1);
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      acc_m     = '0;
      ovf_m     = 1'b0;
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #12 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_acc", acc, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_carry", carry_out, 0);
      check("rst_ovf", overflow, 0);

      do_op(16'h0001, 0, 1'b0);
      do_op(16'h00FE, 0, 1'b0);
      do_op(16'h0001, 0, 1'b0);
      do_op(16'hFEFF, 0, 1'b0);
      do_op(16'h0001, 0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("carry_kept_idle", carry_out, 1);
      do_op(16'h0002, 5, 1'b0);
      do_op(16'h0F0F, 0, 1'b1);

      // Clear and a new operand together: clear wins, operand is dropped.
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'h1234;
      #1;
      check("clear_blocks_ready", in_ready, 0);
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      acc_m    = '0;
      ovf_m    = 1'b0;
      check("clear_acc", acc, 0);
      check("clear_ovf", overflow, 0);
      check("clear_carry", carry_out, 0);
      repeat (NIB + 1) @(posedge clk);
      #1;
      check("clear_no_accept", out_valid, 0);

      for (int k = 0; k < 6; k++) do_op(16'($urandom_range(0, 16'hFFFF)), k % 2, 1'b0);

      // Reset while the third nibble is in flight abandons the operation.
      in_valid = 1'b1;
      in_data  = 16'h0003;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_acc", acc, 0);
      check("async_rst_valid", out_valid, 0);
      check("async_rst_carry", carry_out, 0);
      check("async_rst_ovf", overflow, 0);
      acc_m = '0;
      ovf_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_ready", in_ready, 1);
      check("post_rst_valid", out_valid, 0);
      do_op(16'h0005, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
